// File: rtl/input_spi.sv
// Serial byte receiver: synchronizes a transmitter's sdi/en_in/clk_in into clk,
// assembles bytes on serial clock rising edges and holds them for a consumer.
module input_spi #(
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdi,
    input  logic       en_in,
    input  logic       clk_in,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, RECV, STORE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   clk_prev;
    logic                   edge_r;
    logic                   bit_r;
    logic [7:0]             shreg;
    logic [2:0]             cnt;
    logic                   en_s;
    logic                   clk_s;
    logic                   sdi_s;
    logic                   valid_kept;

    assign en_s       = en_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign sdi_s      = sdi_sync[SYNC_STAGES-1];
    assign valid_kept = valid & ~ack;
    assign busy       = (state == RECV) && (cnt != 3'd0);

    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
        return LSB_FIRST ? {b, cur[7:1]} : {cur[6:0], b};
    endfunction

    // en_in idles high, so its synchronizer resets to 1 to avoid a false frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdi_sync <= '0;
            en_sync  <= '1;
            clk_sync <= '0;
            clk_prev <= 1'b0;
            edge_r   <= 1'b0;
            bit_r    <= 1'b0;
        end else begin
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], en_in};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_in};
            clk_prev <= clk_s;
            edge_r   <= clk_s & ~clk_prev;
            bit_r    <= sdi_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= 8'h00;
            cnt       <= 3'd0;
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            valid     <= valid_kept;
            case (state)
                IDLE: begin
                    shreg <= 8'h00;
                    cnt   <= 3'd0;
                    if (!en_s) state <= RECV;
                end
                RECV: begin
                    if (en_s) begin
                        if (cnt != 3'd0) frame_err <= 1'b1;
                        shreg <= 8'h00;
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end else if (edge_r) begin
                        shreg <= shift_in(shreg, bit_r);
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= STORE;
                    end
                end
                STORE: begin
                    // An ack in this same cycle frees the holding register first.
                    if (valid_kept) begin
                        overrun <= 1'b1;
                    end else begin
                        data  <= shreg;
                        valid <= 1'b1;
                    end
                    if (!en_s) begin
                        state <= RECV;
                        if (edge_r) begin
                            shreg <= shift_in(8'h00, bit_r);
                            cnt   <= 3'd1;
                        end else begin
                            shreg <= 8'h00;
                            cnt   <= 3'd0;
                        end
                    end else begin
                        state <= IDLE;
                        shreg <= 8'h00;
                        cnt   <= 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_spi.sv
// Bench for input_spi: directed scenarios plus randomized bytes, checked against
// a transaction-level model of the held byte, valid and overrun.
module tb_input_spi;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdi;
    logic       en_in;
    logic       clk_in;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       overrun;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int fe_count = 0;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_overrun;

    input_spi #(.SYNC_STAGES(S), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .sdi(sdi), .en_in(en_in), .clk_in(clk_in), .ack(ack),
        .data(data), .valid(valid), .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) fe_count++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"}, {24'h0, data}, {24'h0, m_data});
        check({tag, ".valid"}, {31'h0, valid}, {31'h0, m_valid});
        check({tag, ".overrun"}, {31'h0, overrun}, {31'h0, m_overrun});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".data"}, {24'h0, data}, 32'h0);
        check({tag, ".valid"}, {31'h0, valid}, 32'h0);
        check({tag, ".busy"}, {31'h0, busy}, 32'h0);
        check({tag, ".overrun"}, {31'h0, overrun}, 32'h0);
        check({tag, ".frame_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    // First transmitted bit is b[0]; clk_in is left high after the last bit.
    task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            sdi = b[i];
            tick(half);
            clk_in = 1'b1;
            if (i < nbits - 1) begin
                tick(half);
                clk_in = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int half, input bit ack_same,
                             input bit chk_lat, input string tag);
        int lat;
        lat = 0;
        send_bits(b, 8, half);
        if (ack_same) begin
            tick(S + 2);
            ack = 1'b1;
            tick(1);
            ack = 1'b0;
        end else begin
            for (int k = 1; k <= S + 3; k++) begin
                tick(1);
                if (valid && lat == 0) lat = k;
            end
        end
        if (m_valid && !ack_same) m_overrun = 1'b1;
        else begin
            m_data  = b;
            m_valid = 1'b1;
        end
        check_model(tag);
        check({tag, ".busy"}, {31'h0, busy}, 32'h0);
        if (chk_lat) check({tag, ".latency"}, lat, S + 3);
        clk_in = 1'b0;
        tick(half);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        m_valid = 1'b0;
        check("ack.valid", {31'h0, valid}, 32'h0);
    endtask

    task automatic frame_open();
        en_in = 1'b0;
        tick(4);
    endtask

    task automatic frame_close();
        en_in = 1'b1;
        tick(S + 4);
    endtask

    initial begin
        int fe0;
        logic [7:0] rb;
        rst = 1'b1; sdi = 1'b0; en_in = 1'b1; clk_in = 1'b0; ack = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(S + 3);
        check_reset_outputs("idle");

        // Single byte with exact latency.
        frame_open();
        send_byte(8'hA5, 4, 1'b0, 1'b1, "a5");
        check("a5.frame_err", fe_count, 0);
        do_ack();
        frame_close();

        // Back-to-back bytes in one frame.
        frame_open();
        send_byte(8'h3C, 5, 1'b0, 1'b1, "b2b0");
        do_ack();
        send_byte(8'hC3, 5, 1'b0, 1'b1, "b2b1");
        do_ack();
        frame_close();
        check("b2b.frame_err", fe_count, 0);

        // Overrun: second byte dropped while first is still held.
        frame_open();
        send_byte(8'h11, 4, 1'b0, 1'b0, "ovr0");
        send_byte(8'h22, 4, 1'b0, 1'b0, "ovr1");
        do_ack();
        check_model("ovr.after_ack");
        frame_close();

        // Reset in the middle of a byte.
        fe0 = fe_count;
        frame_open();
        send_bits(8'h9B, 4, 4);
        tick(S + 3);
        check("rst.busy_before", {31'h0, busy}, 32'h1);
        rst = 1'b1; en_in = 1'b1; clk_in = 1'b0; sdi = 1'b0;
        #1;
        check_reset_outputs("rst.async");
        tick(3);
        rst = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
        tick(S + 3);
        check_reset_outputs("rst.after");
        check("rst.frame_err", fe_count, fe0);
        frame_open();
        send_byte(8'hF0, 4, 1'b0, 1'b1, "rst.f0");

        // Ack coinciding with the store of the next byte.
        send_byte(8'h55, 4, 1'b1, 1'b0, "acksame");
        do_ack();
        frame_close();

        // Frame aborted after 5 bits.
        fe0 = fe_count;
        frame_open();
        send_bits(8'h1D, 5, 5);
        tick(S + 3);
        check("ferr.busy_before", {31'h0, busy}, 32'h1);
        clk_in = 1'b0;
        tick(4);
        en_in = 1'b1;
        tick(S + 4);
        check("ferr.pulses", fe_count - fe0, 1);
        check("ferr.busy", {31'h0, busy}, 32'h0);
        check("ferr.valid", {31'h0, valid}, 32'h0);
        frame_open();
        send_byte(8'h7E, 6, 1'b0, 1'b1, "ferr.7e");
        do_ack();
        frame_close();

        // Randomized bytes, acks, ack collisions and frame boundaries.
        fe0 = fe_count;
        frame_open();
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            send_byte(rb, $urandom_range(4, 8), 1'($urandom_range(0, 3) == 0), 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) do_ack();
            if ($urandom_range(0, 3) == 0) begin
                frame_close();
                frame_open();
            end
        end
        frame_close();
        check("rand.frame_err", fe_count, fe0);
        check_model("rand.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
